// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c register-bank controller.
// Contents:
//   BYTE_W   - width of one register / one received byte
//   state_e  - controller states IDLE/PTR/WRITE/DISCARD (2-bit)
//   ptr_w()  - pointer width for a given register count (at least 1 bit)
// Optional feature macro used by the files importing this package:
//   I2C_REG_CTRL_SHADOW_EN
package i2c_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PTR     = 2'd1,
    WRITE   = 2'd2,
    DISCARD = 2'd3
  } state_e;

  // Smallest width able to index n registers; never below one bit.
  function automatic int ptr_w(input int n);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// Register storage for the i2c register-bank controller.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   wr_en_i/addr/data   - single write port driven by the controller
//   regs_o              - flattened live bank, reg k at [8k+7:8k]
//   (I2C_REG_CTRL_SHADOW_EN only)
//   commit_i            - copy every dirty shadow register to live this cycle
//   commit_valid_o      - at least one shadow register is dirty
//   commit_idx_o/data_o - lowest dirty index and its shadow value
// Without I2C_REG_CTRL_SHADOW_EN writes land directly in the live bank.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int                NUM_REGS  = 8,
  parameter logic [BYTE_W-1:0] RESET_VAL = 8'h00,
  parameter int                PTR_W     = ptr_w(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [PTR_W-1:0]             wr_addr_i,
  input  logic [BYTE_W-1:0]            wr_data_i,
`ifdef I2C_REG_CTRL_SHADOW_EN
  input  logic                         commit_i,
  output logic                         commit_valid_o,
  output logic [PTR_W-1:0]             commit_idx_o,
  output logic [BYTE_W-1:0]            commit_data_o,
`endif
  output logic [NUM_REGS*BYTE_W-1:0]   regs_o
);

  logic [NUM_REGS-1:0][BYTE_W-1:0] live_q;
  logic [NUM_REGS-1:0][BYTE_W-1:0] live_d;

`ifdef I2C_REG_CTRL_SHADOW_EN
  logic [NUM_REGS-1:0][BYTE_W-1:0] shadow_q;
  logic [NUM_REGS-1:0][BYTE_W-1:0] shadow_d;
  logic [NUM_REGS-1:0]             dirty_q;
  logic [NUM_REGS-1:0]             dirty_d;

  // Lowest dirty index: scanning downward leaves the smallest match last.
  always_comb begin
    commit_idx_o = {PTR_W{1'b0}};
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      if (dirty_q[k]) begin
        commit_idx_o = k[PTR_W-1:0];
      end else begin
        commit_idx_o = commit_idx_o;
      end
    end
  end

  assign commit_valid_o = |dirty_q;
  assign commit_data_o  = shadow_q[commit_idx_o];

  // Shadow capture, dirty tracking and atomic shadow-to-live copy.
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    if (commit_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (dirty_q[k]) begin
          live_d[k] = shadow_q[k];
        end else begin
          live_d[k] = live_q[k];
        end
      end
      dirty_d = {NUM_REGS{1'b0}};
    end else begin
      dirty_d = dirty_q;
    end
    if (wr_en_i) begin
      shadow_d[wr_addr_i] = wr_data_i;
      dirty_d[wr_addr_i]  = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow bank and dirty mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= {NUM_REGS{RESET_VAL}};
      dirty_q  <= {NUM_REGS{1'b0}};
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end
`else
  // Direct write into the live bank.
  always_comb begin
    live_d = live_q;
    if (wr_en_i) begin
      live_d[wr_addr_i] = wr_data_i;
    end else begin
      live_d = live_q;
    end
  end
`endif

  // Live bank register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= {NUM_REGS{RESET_VAL}};
    end else begin
      live_q <= live_d;
    end
  end

  assign regs_o = live_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-bank controller behind the i2c write-only slave. The first byte
// after START selects the register pointer; each further byte writes the
// register at the pointer, which then auto-increments.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start_i, stop_i     - 1-cycle START / STOP pulses from the slave
//   data_i/data_valid_i - received byte and its 1-cycle qualifier
//   regs_o              - flattened bank, reg k at [8k+7:8k]
//   wr_strobe_o/addr/data - commit report, valid one cycle after the byte
//   busy_o              - high from START until STOP
//   err_o               - sticky error flag, cleared only by reset
// Optional macro I2C_REG_CTRL_SHADOW_EN: writes collect in a shadow bank and
// reach regs_o atomically at STOP; the strobe then reports the lowest
// dirty register of that commit.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int                NUM_REGS  = 8,
  parameter logic [BYTE_W-1:0] RESET_VAL = 8'h00,
  parameter bit                WRAP      = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [BYTE_W-1:0]          data_i,
  input  logic                       data_valid_i,
  output logic [NUM_REGS*BYTE_W-1:0] regs_o,
  output logic                       wr_strobe_o,
  output logic [BYTE_W-1:0]          wr_addr_o,
  output logic [BYTE_W-1:0]          wr_data_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int             PTR_W      = ptr_w(NUM_REGS);
  localparam logic [8:0]     NUM_REGS_9 = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ovr_q, ovr_d;    // DISCARD was entered by running off the end
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [BYTE_W-1:0]  wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]  wr_data_q, wr_data_d;
  logic               wr_en_s;

`ifdef I2C_REG_CTRL_SHADOW_EN
  logic               commit_valid_s;
  logic [PTR_W-1:0]   commit_idx_s;
  logic [BYTE_W-1:0]  commit_data_s;
`endif

  i2c_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL),
    .PTR_W     (PTR_W)
  ) u_bank (
    .clk            (clk),
    .rst            (reset),
    .wr_en_i        (wr_en_s),
    .wr_addr_i      (ptr_q),
    .wr_data_i      (data_i),
`ifdef I2C_REG_CTRL_SHADOW_EN
    .commit_i       (stop_i),
    .commit_valid_o (commit_valid_s),
    .commit_idx_o   (commit_idx_s),
    .commit_data_o  (commit_data_s),
`endif
    .regs_o         (regs_o)
  );

  // Next state, pointer and flags; START/STOP pre-empt any same-cycle byte.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    err_d   = err_q;
    wr_en_s = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      ptr_d   = {PTR_W{1'b0}};
      ovr_d   = 1'b0;
      busy_d  = 1'b0;
      if (data_valid_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (start_i) begin
      state_d = PTR;
      ptr_d   = {PTR_W{1'b0}};
      ovr_d   = 1'b0;
      busy_d  = 1'b1;
      if (data_valid_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (data_valid_i) begin
      case (state_q)
        IDLE: begin
          err_d = 1'b1;
        end
        PTR: begin
          if (9'(data_i) < NUM_REGS_9) begin
            ptr_d   = data_i[PTR_W-1:0];
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            ovr_d   = 1'b0;
            state_d = DISCARD;
          end
        end
        WRITE: begin
          wr_en_s = 1'b1;
          if (ptr_q == LAST_PTR) begin
            if (WRAP) begin
              ptr_d = {PTR_W{1'b0}};
            end else begin
              ovr_d   = 1'b1;
              state_d = DISCARD;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        DISCARD: begin
          // Only an overrun discard flags further bytes; a bad pointer
          // already flagged once on entry.
          if (ovr_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Commit report; address and data hold between strobes.
  always_comb begin
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`ifdef I2C_REG_CTRL_SHADOW_EN
    if (stop_i && commit_valid_s) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = 8'(commit_idx_s);
      wr_data_d   = commit_data_s;
    end else begin
      wr_strobe_d = 1'b0;
    end
`else
    if (wr_en_s) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = 8'(ptr_q);
      wr_data_d   = data_i;
    end else begin
      wr_strobe_d = 1'b0;
    end
`endif
  end

  // Controller state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= {PTR_W{1'b0}};
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
